// File: rtl/ifetch_responder_pkg.sv
// Shared CPU front-end definitions: PC mux select, fetch FSM encoding,
// the NOP used for faulted fetches and the instruction buffer entry layout.
package ifetch_responder_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_BRANCH,
        PC_JUMP,
        PC_EXCEPTION
    } pc_mux_enum;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DREQ,
        DWAIT
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_responder_fifo.sv
// Small instruction buffer (DEPTH x 65 bits) with a synchronous clear that
// beats any same-cycle push or pop.
module ifetch_fifo
    import ifetch_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifetch_responder.sv
// Instruction fetch responder: turns PC fetch requests into single outstanding
// memory transactions and buffers the results for decode.
module ifetch_responder
    import ifetch_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e   state;
    fetch_state_e   state_next;
    logic [CW-1:0]  count;
    logic           accept;
    logic           aligned;
    logic           push;
    logic           pop;
    fetch_entry_t   push_entry;
    fetch_entry_t   head;

    assign aligned = (fetch_addr[1:0] == 2'b00);

    // A flush turns the live request into its discard twin; if the request
    // completes in the flush cycle it simply retires without pushing.
    always_comb begin
        state_next  = state;
        fetch_ready = (state == IDLE) && !flush && (count < CW'(DEPTH));
        accept      = fetch_valid && fetch_ready;
        push        = 1'b0;
        push_entry  = '{inst: NOP_INST, pc: fetch_addr, fault: 1'b1};
        case (state)
            IDLE: begin
                if (accept) begin
                    if (aligned) begin
                        state_next = REQ;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            REQ, DREQ: begin
                if (mem_gnt) begin
                    state_next = (flush || state == DREQ) ? DWAIT : WAIT;
                end else if (flush) begin
                    state_next = DREQ;
                end
            end
            WAIT, DWAIT: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                    if (state == WAIT && !flush) begin
                        push       = 1'b1;
                        push_entry = '{inst: mem_rdata, pc: mem_addr, fault: 1'b0};
                    end
                end else if (flush) begin
                    state_next = DWAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
        end else begin
            state <= state_next;
            if (accept && aligned) begin
                mem_addr <= fetch_addr;
            end
        end
    end

    assign mem_req    = (state == REQ) || (state == DREQ);
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_fault = head.fault;

    ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule
